alu_wb_fifo: RTL and testbench

Elastic result buffer between the ALU stage and the writeback stage. It accepts ALU results with a valid/ready handshake in the ALU clock domain. Each entry is delivered to writeback over a four-phase req/ack handshake, with `ack` synchronised into the local clock. Writeback always sees stable data while `req` is high, and the ALU stalls only when the buffer is full.

---
 rtl/alu_wb_fifo.sv | 135 +++++++++++++
 tb/tb_alu_wb_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_fifo.sv
// rtl/alu_wb_fifo.sv - ALU result buffer with four-phase req/ack delivery to writeback
// Optional stall counter port: define ALU_WB_FIFO_STATS_EN.
module alu_wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [ADDR_W-1:0]        in_rd,
  output logic                     req,
  input  logic                     ack,
  output logic [DATA_W-1:0]        out_result,
  output logic [ADDR_W-1:0]        out_rd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef ALU_WB_FIFO_STATS_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_result [DEPTH];
  logic [ADDR_W-1:0] mem_rd     [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              ack_meta, ack_s;
  logic              push, pop, load;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= ack;
      ack_s    <= ack_meta;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        // A still-high ack_s means writeback has not finished the last
        // handshake; wait here rather than raising a new request.
        if (!empty && !ack_s) begin
          load    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          pop     = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      req        <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
    end else begin
      state_q <= state_d;
      req     <= (state_d == REQ);
      if (load) begin
        out_result <= mem_result[rd_ptr];
        out_rd     <= mem_rd[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= in_result;
      mem_rd[wr_ptr]     <= in_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_WB_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_fifo.sv
// tb/tb_alu_wb_fifo.sv - self-checking bench for alu_wb_fifo
module tb_alu_wb_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [3:0]  in_rd;
  logic        req;
  logic        ack;
  logic [15:0] out_result;
  logic [3:0]  out_rd;
  logic [2:0]  count;
  logic        full;
  logic        empty;
`ifdef ALU_WB_FIFO_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  alu_wb_fifo #(.DEPTH(4), .DATA_W(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_rd      (in_rd),
    .req        (req),
    .ack        (ack),
    .out_result (out_result),
    .out_rd     (out_rd),
    .count      (count),
    .full       (full),
    .empty      (empty)
`ifdef ALU_WB_FIFO_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [3:0]  rd;
    logic        a;
    logic [2:0]  cnt;
    logic        rq;
    logic        fl;
    logic        em;
    logic [15:0] o;
    logic [3:0]  ord;
    logic [15:0] st;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; in_result = '0; in_rd = '0; ack = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic push1(input logic [15:0] d, input logic [3:0] r);
    in_valid = 1'b1; in_result = d; in_rd = r;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int pushed, rcv, age, unstable, viol;
    logic acc, req_prev;
    logic [15:0] cap;

    tbl[0]  = '{1'b1, 16'h00A5, 4'd3, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'd0};
    tbl[1]  = '{1'b0, 16'h0000, 4'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 16'h00A5, 4'd3, 16'd0};
    tbl[2]  = '{1'b0, 16'h0000, 4'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 16'h00A5, 4'd3, 16'd0};
    tbl[3]  = '{1'b0, 16'h0000, 4'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 16'h00A5, 4'd3, 16'd0};
    tbl[4]  = '{1'b0, 16'h0000, 4'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 16'h00A5, 4'd3, 16'd0};
    tbl[5]  = '{1'b0, 16'h0000, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h00A5, 4'd3, 16'd0};
    tbl[6]  = '{1'b0, 16'h0000, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h00A5, 4'd3, 16'd0};
    tbl[7]  = '{1'b0, 16'h0000, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h00A5, 4'd3, 16'd0};
    tbl[8]  = '{1'b1, 16'h0001, 4'd1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 16'h00A5, 4'd3, 16'd0};
    tbl[9]  = '{1'b1, 16'h0002, 4'd2, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0001, 4'd1, 16'd0};
    tbl[10] = '{1'b1, 16'h0003, 4'd3, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0001, 4'd1, 16'd0};
    tbl[11] = '{1'b1, 16'h0004, 4'd4, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 16'h0001, 4'd1, 16'd0};
    tbl[12] = '{1'b1, 16'h0005, 4'd5, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 16'h0001, 4'd1, 16'd1};
    tbl[13] = '{1'b1, 16'h0005, 4'd5, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 16'h0001, 4'd1, 16'd2};

    // Reset state
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_out", {12'd0, out_rd, out_result}, 32'd0);

    // Single entry handshake, then fill and stall
    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].v; in_result = tbl[i].d; in_rd = tbl[i].rd; ack = tbl[i].a;
      step();
      chk($sformatf("row%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("row%0d_req", i), 32'(req), 32'(tbl[i].rq));
      chk($sformatf("row%0d_full", i), 32'(full), 32'(tbl[i].fl));
      chk($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(!tbl[i].fl));
      chk($sformatf("row%0d_empty", i), 32'(empty), 32'(tbl[i].em));
      chk($sformatf("row%0d_out", i), {12'd0, out_rd, out_result}, {12'd0, tbl[i].ord, tbl[i].o});
`ifdef ALU_WB_FIFO_STATS_EN
      chk($sformatf("row%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].st));
`endif
    end
    in_valid = 1'b0;

    // Order and wrap: 10 entries, ack answers each req one cycle later
    do_reset();
    pushed = 0; rcv = 0; age = 0; unstable = 0; acc = 1'b0; req_prev = 1'b0; cap = '0;
    for (int cyc = 0; cyc < 400 && !(rcv == 10 && count == 3'd0 && !req); cyc++) begin
      if (acc) pushed++;
      in_valid = (pushed < 10);
      in_result = 16'h1000 + 16'(pushed);
      in_rd = 4'(pushed);
      acc = in_valid && in_ready;
      if (req && !req_prev) begin
        chk($sformatf("order%0d", rcv), {12'd0, out_rd, out_result}, {12'd0, 4'(rcv), 16'h1000 + 16'(rcv)});
        cap = out_result;
        rcv++;
      end else if (req && out_result !== cap) begin
        unstable++;
      end
      if (req && !ack) begin
        if (age >= 1) ack = 1'b1;
        age++;
      end else begin
        age = 0;
      end
      if (!req && ack) ack = 1'b0;
      req_prev = req;
      step();
    end
    in_valid = 1'b0; ack = 1'b0;
    chk("wrap_received", 32'(rcv), 32'd10);
    chk("wrap_count", 32'(count), 32'd0);
    chk("wrap_stable", 32'(unstable), 32'd0);

    // Simultaneous push and pop with count=2
    do_reset();
    push1(16'h000A, 4'd1);
    push1(16'h000B, 4'd2);
    chk("pp_pre_count", 32'(count), 32'd2);
    chk("pp_pre_req", 32'(req), 32'd1);
    ack = 1'b1;
    step();
    step();
    push1(16'h000C, 4'd3);
    chk("pp_count", 32'(count), 32'd2);
    chk("pp_req_low", 32'(req), 32'd0);
    ack = 1'b0;
    for (int i = 0; i < 10 && !req; i++) step();
    chk("pp_next_req", 32'(req), 32'd1);
    chk("pp_next_entry", {12'd0, out_rd, out_result}, {12'd0, 4'd2, 16'h000B});

    // Reset mid-handshake with 3 entries buffered
    do_reset();
    push1(16'h0011, 4'd1);
    push1(16'h0012, 4'd2);
    push1(16'h0013, 4'd3);
    chk("mid_pre_count", 32'(count), 32'd3);
    chk("mid_pre_req", 32'(req), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_req", 32'(req), 32'd0);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_out", {12'd0, out_rd, out_result}, 32'd0);
    viol = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (req) viol++;
    end
    chk("mid_no_req", 32'(viol), 32'd0);
    push1(16'h0014, 4'd4);
    step();
    chk("mid_new_req", 32'(req), 32'd1);
    chk("mid_new_entry", {12'd0, out_rd, out_result}, {12'd0, 4'd4, 16'h0014});

    // Stuck ack in IDLE
    do_reset();
    ack = 1'b1;
    step();
    step();
    step();
    push1(16'h00D0, 4'd7);
    viol = 0;
    for (int i = 0; i < 6; i++) begin
      if (req) viol++;
      step();
    end
    chk("stuck_no_req", 32'(viol), 32'd0);
    chk("stuck_count", 32'(count), 32'd1);
    ack = 1'b0;
    for (int i = 0; i < 4 && !req; i++) step();
    chk("stuck_req_rise", 32'(req), 32'd1);
    chk("stuck_entry", {12'd0, out_rd, out_result}, {12'd0, 4'd7, 16'h00D0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
